// File: rtl/mul_issue_ctrl.sv
// Issue controller for a fixed-latency multiplier: queues operand pairs in a small FIFO,
// sequences clear/start/wait/capture for each pair and presents the product with taint.
module mul_issue_ctrl #(
   parameter int NUM_BITS = 7,
   parameter int DEPTH    = 4,
   parameter int LATENCY  = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_BITS-1:0]           in_multiplier,
   input  logic [NUM_BITS-1:0]           in_multiplicand,
   input  logic [NUM_BITS-1:0]           in_multiplier_t,
   input  logic [NUM_BITS-1:0]           in_multiplicand_t,
   output logic                          mul_rst,
   output logic                          mul_start,
   output logic [NUM_BITS-1:0]           mul_multiplier,
   output logic [NUM_BITS-1:0]           mul_multiplicand,
   output logic                          mul_start_t,
   output logic [NUM_BITS-1:0]           mul_multiplier_t,
   output logic [NUM_BITS-1:0]           mul_multiplicand_t,
   input  logic [2*NUM_BITS-1:0]         mul_product,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2*NUM_BITS-1:0]         out_product,
   output logic                          out_product_t,
   output logic [$clog2(DEPTH):0]        fifo_count,
   output logic                          busy
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0]   LAST_CNT = CW'(LATENCY - 1);
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      CAP   = 3'd4
   } state_t;

   state_t state, state_next;

   logic [NUM_BITS-1:0] fifo_mr   [DEPTH];
   logic [NUM_BITS-1:0] fifo_md   [DEPTH];
   logic [NUM_BITS-1:0] fifo_mr_t [DEPTH];
   logic [NUM_BITS-1:0] fifo_md_t [DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;

   logic [NUM_BITS-1:0] hold_mr, hold_md, hold_mr_t, hold_md_t;
   logic [CW-1:0]       cnt, cnt_next;

   logic push, pop, load_out;

   assign in_ready = (fifo_count < FULL_CNT);
   assign push     = in_valid && in_ready;
   assign pop      = (state == IDLE) && (fifo_count != '0);

   // Storage needs no reset: only pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mr[wr_ptr]   <= in_multiplier;
         fifo_md[wr_ptr]   <= in_multiplicand;
         fifo_mr_t[wr_ptr] <= in_multiplier_t;
         fifo_md_t[wr_ptr] <= in_multiplicand_t;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_mr   <= '0;
         hold_md   <= '0;
         hold_mr_t <= '0;
         hold_md_t <= '0;
      end else if (pop) begin
         hold_mr   <= fifo_mr[rd_ptr];
         hold_md   <= fifo_md[rd_ptr];
         hold_mr_t <= fifo_mr_t[rd_ptr];
         hold_md_t <= fifo_md_t[rd_ptr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      load_out   = 1'b0;
      case (state)
         IDLE:  if (fifo_count != '0) state_next = CLR;
         CLR:   state_next = START;
         START: begin
            state_next = WAIT;
            cnt_next   = '0;
         end
         WAIT: begin
            if (cnt == LAST_CNT) state_next = CAP;
            else                 cnt_next   = cnt + 1'b1;
         end
         CAP: begin
            // A result still waiting for the consumer blocks the capture.
            if (!out_valid || out_ready) begin
               load_out   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_product   <= '0;
         out_product_t <= 1'b0;
      end else if (load_out) begin
         out_valid     <= 1'b1;
         out_product   <= mul_product;
         out_product_t <= (|hold_mr_t) | (|hold_md_t);
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

   assign mul_rst            = rst | (state == CLR);
   assign mul_start          = (state == START);
   assign mul_start_t        = 1'b0;
   assign mul_multiplier     = hold_mr;
   assign mul_multiplicand   = hold_md;
   assign mul_multiplier_t   = hold_mr_t;
   assign mul_multiplicand_t = hold_md_t;
   assign busy               = (state != IDLE) || (fifo_count != '0);

endmodule
